// File: rtl/hack_cpu_ctrl.sv
// Hack CPU control/register half: holds A, D and PC, decodes Hack instructions,
// drives the external ALU and commits its result. Instruction fetch uses a
// valid/ready handshake; data-memory writes stall until the memory acknowledges.
module hack_cpu_ctrl #(
    parameter int PC_W  = 15,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      instr,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [15:0]      inM,
    output logic [15:0]      alu_x,
    output logic [15:0]      alu_y,
    output logic             alu_zx,
    output logic             alu_nx,
    output logic             alu_zy,
    output logic             alu_ny,
    output logic             alu_f,
    output logic             alu_no,
    input  logic [15:0]      alu_out,
    input  logic             alu_zr,
    input  logic             alu_ng,
    output logic [15:0]      outM,
    output logic [PC_W-1:0]  addressM,
    output logic             writeM,
    input  logic             mem_ack,
    output logic [PC_W-1:0]  pc,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [0:0] {
        EXEC     = 1'b0,
        WAIT_MEM = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [15:0]      a_reg;
    logic [15:0]      d_reg;
    logic [PC_W-1:0]  pc_reg;
    logic [CNT_W-1:0] retired_reg;
    logic [15:0]      out_hold;
    logic [PC_W-1:0]  addr_hold;

    logic             is_c;
    logic             a_bit;
    logic [5:0]       comp;
    logic             dest_a;
    logic             dest_d;
    logic             dest_m;
    logic             jump_taken;
    logic             fire;
    logic             write_req;
    logic             stall;
    logic [PC_W-1:0]  a_addr;
    logic [PC_W-1:0]  pc_inc;
    logic             unused_bits;

    assign is_c   = instr[15];
    assign a_bit  = instr[12];
    assign comp   = instr[11:6];
    assign dest_a = instr[5];
    assign dest_d = instr[4];
    assign dest_m = instr[3];

    // instr[14:13] carry no meaning in a C-instruction
    assign unused_bits = ^instr[14:13];

    assign a_addr    = a_reg[PC_W-1:0];
    assign pc_inc    = pc_reg + PC_W'(1);
    assign fire      = (state == EXEC) & instr_valid;
    assign write_req = fire & is_c & dest_m;
    assign stall     = write_req & ~mem_ack;

    // Jump condition uses the ALU flags of the result being committed this cycle
    assign jump_taken = (instr[2] & alu_ng)
                      | (instr[1] & alu_zr)
                      | (instr[0] & ~alu_zr & ~alu_ng);

    // x is always D; y selects memory when the a-bit of a C-instruction is set
    assign alu_x = d_reg;
    assign alu_y = (is_c & a_bit) ? inM : a_reg;

    assign pc      = pc_reg;
    assign retired = retired_reg;

    // State register: a pending write is dropped by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EXEC;
        end else begin
            state <= state_next;
        end
    end

    // Next state: enter WAIT_MEM on an unacknowledged write, leave on mem_ack
    always_comb begin
        state_next = state;
        if (state == EXEC) begin
            if (stall) begin
                state_next = WAIT_MEM;
            end
        end else begin
            if (mem_ack) begin
                state_next = EXEC;
            end
        end
    end

    // Outputs: live ALU/decode values in EXEC, latched write held in WAIT_MEM
    always_comb begin
        instr_ready = 1'b0;
        {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = 6'b000000;
        outM        = out_hold;
        addressM    = addr_hold;
        writeM      = 1'b1;
        if (state == EXEC) begin
            instr_ready = 1'b1;
            if (is_c) begin
                {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = comp;
            end
            outM     = alu_out;
            addressM = a_addr;
            writeM   = write_req;
        end
    end

    // Register commit: A/D/PC/counter update once per accepted instruction
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg       <= '0;
            d_reg       <= '0;
            pc_reg      <= '0;
            retired_reg <= '0;
            out_hold    <= '0;
            addr_hold   <= '0;
        end else begin
            if (fire) begin
                retired_reg <= retired_reg + CNT_W'(1);
                if (!is_c) begin
                    a_reg  <= {1'b0, instr[14:0]};
                    pc_reg <= pc_inc;
                end else begin
                    if (dest_a) begin
                        a_reg <= alu_out;
                    end
                    if (dest_d) begin
                        d_reg <= alu_out;
                    end
                    pc_reg <= jump_taken ? a_addr : pc_inc;
                end
            end
            if (stall) begin
                out_hold  <= alu_out;
                addr_hold <= a_addr;
            end
        end
    end

endmodule

// File: doc/hack_cpu_ctrl.md
Name: hack_cpu_ctrl

Overview:
Control and register half of the Hack CPU. It is the initiator side of the ALU interface: it holds the A, D and PC registers and decodes Hack instructions. Each cycle it drives the ALU operands and the six control bits zx..no, then consumes the ALU's out, zr and ng to commit register writes, memory writes and jumps. It adds an instruction-valid handshake and a stalling data-memory write handshake, so it can sit in front of slow instruction and data memories.

Parameters:
PC_W, 15, width of the PC and of addressM
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  synchronous active-low reset
instr  in  16  instruction word addressed by pc
instr_valid  in  1  instr is valid this cycle
instr_ready  out  1  controller accepts instr this cycle
inM  in  16  data memory read value at addressM, combinational, same cycle
alu_x  out  16  ALU x operand, always D
alu_y  out  16  ALU y operand, inM when a=1, else A
alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  out  1 each  ALU control bits
alu_out  in  16  ALU result
alu_zr  in  1  ALU result == 0
alu_ng  in  1  ALU result < 0
outM  out  16  data memory write value
addressM  out  PC_W  data memory address
writeM  out  1  data memory write strobe
mem_ack  in  1  data memory accepted the write this cycle
pc  out  PC_W  instruction address
retired  out  CNT_W  count of committed instructions

Behaviour:
- Synchronous reset (rst_n=0 at edge):
  - A, D, pc, retired = 0.
  - state = EXEC.
  - writeM deasserts from the next cycle.
  - Reset overrides everything, including a pending write in WAIT_MEM; that write is dropped.
- FSM states:
  - EXEC: instr_ready=1.
  - WAIT_MEM: instr_ready=0.
- Fire condition: fire = EXEC & instr_valid. With no fire, A, D, pc and retired hold, and writeM=0.
- A-instruction (instr[15]=0), on fire:
  - A <= {0,instr[14:0]}.
  - pc <= pc+1.
  - ALU control outputs are all 0 and writeM=0.
- C-instruction (instr[15]=1), decode:
  - instr[14:13] ignored; a=instr[12].
  - {zx,nx,zy,ny,f,no} = instr[11:6], driven combinationally while in EXEC.
  - d = instr[5:3] as {dA,dD,dM}.
  - j = instr[2:0] as {lt,eq,gt}.
- C-instruction, on fire:
  - If dA: A <= alu_out.
  - If dD: D <= alu_out.
  - Jump taken = (lt&alu_ng) | (eq&alu_zr) | (gt&~alu_zr&~alu_ng).
  - pc <= taken ? A[PC_W-1:0] (old A) : pc+1.
- Memory write on a C-instruction:
  - In EXEC, outM=alu_out, addressM=A (old A), writeM=fire&dM.
  - If writeM & mem_ack, the write completes in the same cycle.
  - If writeM & ~mem_ack:
    - Latch outM and addressM.
    - Commit the A, D and pc updates normally.
    - Go to WAIT_MEM.
- WAIT_MEM:
  - writeM=1, and the latched outM/addressM are held stable.
  - ALU controls are 0.
  - On mem_ack, return to EXEC on the next edge.
- Cycle counts: a non-stalled instruction takes 1 cycle. A write takes 1+N cycles, where N is the number of cycles until mem_ack.
- retired increments by 1 on every fire and wraps modulo 2^CNT_W. A stalled write still counts once.
- pc wraps modulo 2^PC_W.
- Outside EXEC-fire, addressM still shows A and outM shows alu_out, but writeM=0.
- When dA and a jump occur together, the jump target is the pre-update A.

Test Plan:
- Reset, then stream @5 (0x0005), D=A (0xEC10) -> D=5, A=5, pc=2, retired=2. D=A drives alu controls 110000 and alu_y=5.
- @7, D=A, @20 (0x0014), M=D (0xE308) with mem_ack=1 -> writeM=1 for one cycle, addressM=20, outM=7, pc=4, no stall.
- M=D with mem_ack held low for 3 cycles -> writeM high for 4 cycles, addressM/outM stable, instr_ready=0 for 3 cycles, pc advances once, retired +1.
- @10, 0;JMP (0xEA87) -> pc=10. D=-1 then @3, D;JGT (0xE301) -> pc=pc+1 (not taken). D=1 then the same -> pc=3.
- AM=M+1 (0xFDE8) with A=4, inM=9 -> alu_y=9, addressM=4, outM=10, A=10 after the edge.
- Assert rst_n=0 during WAIT_MEM -> next cycle writeM=0, A=D=pc=retired=0, instr_ready=1. instr_valid=0 for 5 cycles -> no state change.
